vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between two requesters: VGA scan-out and a pixel writer (CPU/drawing engine).
- Consumes the timing generator's h_count/v_count, prefetches each visible pixel ahead of its display time, and delivers a registered pixel aligned to the counters.
- Display fetches always win; the writer is granted only in cycles with no fetch (blanking and fetch gaps). Uses a req/ack handshake.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- H_TOTAL, 800, clocks per line (h_count range 0..799)
- V_TOTAL, 525, lines per frame (v_count range 0..524)
- ADDR_W, 19, framebuffer address width (640*480 = 307200 words)
- DATA_W, 8, pixel width
- MEM_LAT, 1, RAM synchronous read latency in clocks; the fetch lead is RD_LAT = MEM_LAT+1

Ports:
- clk  in  1  pixel clock (one pixel per clock)
- rst  in  1  asynchronous, active-low reset
- h_count  in  10  horizontal counter; increments by 1 per clk, wraps at H_TOTAL-1
- v_count  in  10  vertical counter; increments when h_count wraps, wraps at V_TOTAL-1
- wr_req  in  1  writer request; held until wr_ack
- wr_addr  in  ADDR_W  write address; stable while wr_req is high
- wr_data  in  DATA_W  write data; stable while wr_req is high
- wr_ack  out  1  one-cycle pulse: write has been performed
- mem_addr  out  ADDR_W  RAM address (combinational)
- mem_we  out  1  RAM write enable (combinational)
- mem_wdata  out  DATA_W  RAM write data (combinational, equals wr_data)
- mem_rdata  in  DATA_W  RAM read data, valid MEM_LAT clocks after the address
- pix_data  out  DATA_W  registered pixel for the current (h_count, v_count); 0 when blank
- pix_valid  out  1  registered; 1 when the current (h_count, v_count) is visible

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - wr_ack=0, pix_data=0, pix_valid=0, read pipeline valid bits=0, FSM=W_IDLE.
  - mem_we is gated to 0 combinationally while rst=0.
- Fetch coordinates, computed combinationally from the current counters:
  - hx = h_count+RD_LAT.
  - fx = hx if hx<H_TOTAL, else hx-H_TOTAL.
  - fy = v_count if hx<H_TOTAL, else (v_count+1 if v_count<V_TOTAL-1, else 0).
- fetch_active = (fx<H_ACTIVE) and (fy<V_ACTIVE).
- Fetch address = fy*H_ACTIVE+fx, computed at ADDR_W width; 640 = 512+128 (shift-add). No multiplier is required.
- Pixel alignment:
  - A read issued in cycle t is captured from mem_rdata into pix_data at the end of cycle t+MEM_LAT.
  - In any cycle where the inputs read (h, v), pix_data holds framebuffer[v*640+h] for visible positions.
  - A valid bit travels with each fetch. pix_data loads 0 and pix_valid loads 0 when the arriving slot was not a fetch.
  - Column 0 of line v is fetched during the last RD_LAT clocks of line v-1. Pixel (0,0) is fetched at h=798, v=524.
- Mux rule:
  - If fetch_active: mem_addr = fetch address, mem_we=0.
  - Else if the FSM is in W_IDLE and wr_req=1: mem_addr=wr_addr, mem_we=1.
  - Otherwise: mem_addr = fetch address, mem_we=0.
- Writer FSM:
  - W_IDLE: wr_req & !fetch_active → write issued this cycle → W_ACK.
  - W_IDLE: wr_req & fetch_active → stay in W_IDLE (stall).
  - W_ACK: wr_ack=1 for exactly one cycle → W_IDLE.
  - wr_req is ignored during W_ACK; a back-to-back writer may re-request in the cycle after the ack.
- Throughput: in the 160 horizontal blanking columns the writer gets up to one write per 2 clocks. Vertical blanking lines are fully available except the prefetch window at line 524, h≥798.
- Writes inside a visible line stall until that line's fetch gap. No starvation timeout exists; the worst-case wait is ≤ 640 clocks.
- Reset asserted mid-handshake: the pending ack is lost and the writer must re-request. A write already clocked into the RAM is not undone.
- Counter values outside range (h≥H_TOTAL or v≥V_TOTAL) are undefined input. The block must not hang: fetch_active evaluates per the formulas.

Decomposition:
- Package vga_pkg holds:
  - H_ACTIVE, V_ACTIVE, H_TOTAL, V_TOTAL, ADDR_W, DATA_W.
  - The pixel_t and fb_addr_t typedefs.
  - The writer-FSM enum (W_IDLE, W_ACK).
- Sub-module vga_fetch_addr: combinational hx/fx/fy wrap logic, fetch_active, and shift-add address.
- Arbitration mux, writer FSM and read pipeline stay in the top module.

Test Plan:
- Reset, then release at h=0, v=0 with a RAM model filled with addr[7:0] → in the cycle where h=5, v=0, pix_data=0x05 and pix_valid=1; pix_data=0, pix_valid=0 at h=640..799.
- Counters at h=798, v=524 → mem_addr=0 with mem_we=0; at h=0, v=0, pix_data=RAM[0] and pix_valid=1. Also at h=798, v=10 → mem_addr=11*640=7040.
- wr_req with wr_addr=1234, wr_data=0xA5 raised at h=100, v=20 → mem_we first asserted at h=638, v=20 (fx≥640), RAM[1234]=0xA5, wr_ack pulse at h=639; display pixels unaffected.
- wr_req held continuously during v=490 → writes on alternating clocks (we, ack, we, ...); no two consecutive mem_we cycles.
- rst driven low in the W_ACK cycle → wr_ack=0 immediately, pix_valid=0; after release the FSM is in W_IDLE and the re-issued request completes normally.
- Full frame with the RAM holding a random image → every visible pixel on pix_data matches its expected RAM word; pix_valid count is 307200 per frame.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants, types and writer FSM states for the VGA framebuffer arbiter
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 8;
    localparam int MEM_LAT  = 1;
    localparam int RD_LAT   = MEM_LAT + 1;

    typedef logic [DATA_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef enum logic {
        W_IDLE,
        W_ACK
    } wr_state_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - writer handshake and framebuffer RAM port bundle
interface vga_fb_arbiter_if;
    import vga_pkg::*;

    logic     wr_req;
    fb_addr_t wr_addr;
    pixel_t   wr_data;
    logic     wr_ack;
    fb_addr_t mem_addr;
    logic     mem_we;
    pixel_t   mem_wdata;
    pixel_t   mem_rdata;

    // master: writer + RAM side; slave: the arbiter
    modport master (
        output wr_req, wr_addr, wr_data, mem_rdata,
        input  wr_ack, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, mem_rdata,
        output wr_ack, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/vga_fetch_addr.sv
// rtl/vga_fetch_addr.sv - look-ahead fetch coordinates, visibility and framebuffer address
module vga_fetch_addr
    import vga_pkg::*;
(
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    output logic       fetch_active,
    output fb_addr_t   fetch_addr
);

    logic [10:0] hx;
    logic        wrap;
    logic [9:0]  fx;
    logic [9:0]  fy;

    always_comb begin
        hx   = {1'b0, h_count} + 11'(RD_LAT);
        wrap = (hx >= 11'(H_TOTAL));
        fx   = wrap ? 10'(hx - 11'(H_TOTAL)) : hx[9:0];
        if (!wrap)
            fy = v_count;
        else if (v_count < 10'(V_TOTAL - 1))
            fy = v_count + 10'd1;
        else
            fy = '0;
        fetch_active = (fx < 10'(H_ACTIVE)) && (fy < 10'(V_ACTIVE));
        // fy*640 as fy*512 + fy*128
        fetch_addr = (fb_addr_t'(fy) << 9) + (fb_addr_t'(fy) << 7) + fb_addr_t'(fx);
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer shared between display prefetch and a pixel writer
module vga_fb_arbiter
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    vga_fb_arbiter_if.slave   bus,
    output pixel_t            pix_data,
    output logic              pix_valid
);

    wr_state_e            state;
    wr_state_e            state_nxt;
    logic                 fetch_active;
    fb_addr_t             fetch_addr;
    logic                 write_go;
    logic [MEM_LAT-1:0]   vpipe;

    vga_fetch_addr u_fetch (
        .h_count      (h_count),
        .v_count      (v_count),
        .fetch_active (fetch_active),
        .fetch_addr   (fetch_addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= W_IDLE;
        else
            state <= state_nxt;
    end

    // Display fetch owns the port; the writer only gets slots with no fetch
    always_comb begin
        state_nxt     = state;
        write_go      = 1'b0;
        bus.wr_ack    = 1'b0;
        case (state)
            W_IDLE: begin
                if (bus.wr_req && !fetch_active) begin
                    write_go  = 1'b1;
                    state_nxt = W_ACK;
                end
            end
            W_ACK: begin
                bus.wr_ack = 1'b1;
                state_nxt  = W_IDLE;
            end
        endcase
        bus.mem_we    = write_go && rst;
        bus.mem_addr  = write_go ? bus.wr_addr : fetch_addr;
        bus.mem_wdata = bus.wr_data;
    end

    // Visibility bit rides alongside each read so non-fetch slots blank the pixel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vpipe     <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            vpipe     <= MEM_LAT'({vpipe, fetch_active});
            pix_valid <= vpipe[MEM_LAT-1];
            pix_data  <= vpipe[MEM_LAT-1] ? bus.mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] h_count = '0;
    logic [9:0] v_count = '0;
    pixel_t     pix_data;
    logic       pix_valid;
    int         fill_mode = 0;
    int         total = 0;
    int         bad = 0;

    logic [7:0] ram [0:307199];

    vga_fb_arbiter_if bus ();

    vga_fb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .h_count   (h_count),
        .v_count   (v_count),
        .bus       (bus),
        .pix_data  (pix_data),
        .pix_valid (pix_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fill_mode == 1)
            for (int i = 0; i < 307200; i++) ram[i] <= 8'(i);
        else if (fill_mode == 2)
            for (int i = 0; i < 307200; i++) ram[i] <= 8'($urandom);
        else if (fill_mode == 3)
            ram[0] <= 8'hC3;
        if (bus.mem_we && bus.mem_addr < 19'd307200)
            ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= (bus.mem_addr < 19'd307200) ? ram[bus.mem_addr] : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (h_count == 10'd799) begin
            h_count = '0;
            v_count = (v_count == 10'd524) ? 10'd0 : v_count + 10'd1;
        end else begin
            h_count = h_count + 10'd1;
        end
        #1;
    endtask

    task automatic set_pos(input int h, input int v);
        h_count = 10'(h);
        v_count = 10'(v);
        #1;
    endtask

    task automatic fill(input int mode);
        fill_mode = mode;
        @(posedge clk);
        #1;
        fill_mode = 0;
        #1;
    endtask

    task automatic test_reset();
        int errs;
        rst = 1'b0;
        bus.wr_req = 1'b1;
        bus.wr_addr = 19'd42;
        bus.wr_data = 8'h99;
        set_pos(700, 0);
        fill(1);
        repeat (2) @(posedge clk);
        #2;
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL reset_pix_valid got=%0h want=0", pix_valid); end
        total++; if (pix_data !== 8'h00) begin bad++; $display("FAIL reset_pix_data got=%0h want=0", pix_data); end
        total++; if (bus.wr_ack !== 1'b0) begin bad++; $display("FAIL reset_wr_ack got=%0h want=0", bus.wr_ack); end
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we_gated got=%0h want=0", bus.mem_we); end
        bus.wr_req = 1'b0;
        set_pos(0, 0);
        rst = 1'b1;
        repeat (5) tick();
        total++; if (pix_data !== 8'h05 || pix_valid !== 1'b1) begin bad++; $display("FAIL pixel_h5 got=%0h/%0h want=05/1", pix_data, pix_valid); end
        repeat (634) tick();
        total++; if (pix_data !== 8'h7F || pix_valid !== 1'b1) begin bad++; $display("FAIL pixel_h639 got=%0h/%0h want=7f/1", pix_data, pix_valid); end
        tick();
        errs = 0;
        for (int i = 0; i < 160; i++) begin
            if (pix_valid !== 1'b0 || pix_data !== 8'h00) errs++;
            tick();
        end
        total++; if (errs != 0) begin bad++; $display("FAIL hblank_pixels got=%0d bad cycles want=0", errs); end
    endtask

    task automatic test_prefetch();
        fill(3);
        set_pos(798, 524);
        total++; if (bus.mem_addr !== 19'd0 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL prefetch_addr_0 got=%0d/%0h want=0/0", bus.mem_addr, bus.mem_we); end
        tick();
        tick();
        total++; if (pix_data !== 8'hC3 || pix_valid !== 1'b1) begin bad++; $display("FAIL pixel_0_0 got=%0h/%0h want=c3/1", pix_data, pix_valid); end
        tick();
        total++; if (pix_data !== 8'h01 || pix_valid !== 1'b1) begin bad++; $display("FAIL pixel_1_0 got=%0h/%0h want=01/1", pix_data, pix_valid); end
        set_pos(798, 10);
        total++; if (bus.mem_addr !== 19'd7040) begin bad++; $display("FAIL prefetch_addr_line11 got=%0d want=7040", bus.mem_addr); end
    endtask

    task automatic test_write_stall();
        int first_h, first_v, errs;
        logic [18:0] addr_at_we;
        first_h = -1; first_v = -1; errs = 0; addr_at_we = '0;
        set_pos(100, 20);
        bus.wr_addr = 19'd1234;
        bus.wr_data = 8'hA5;
        bus.wr_req = 1'b1;
        #1;
        for (int i = 0; i < 1000; i++) begin
            if (h_count >= 10'd102 && h_count < 10'd640 &&
                (pix_valid !== 1'b1 || pix_data !== 8'(20 * 640 + int'(h_count)))) errs++;
            if (bus.mem_we === 1'b1) begin
                first_h = int'(h_count);
                first_v = int'(v_count);
                addr_at_we = bus.mem_addr;
                break;
            end
            tick();
        end
        total++; if (first_h != 638 || first_v != 20) begin bad++; $display("FAIL write_first_slot got=h%0d v%0d want=h638 v20", first_h, first_v); end
        total++; if (addr_at_we !== 19'd1234) begin bad++; $display("FAIL write_addr got=%0d want=1234", addr_at_we); end
        total++; if (errs != 0) begin bad++; $display("FAIL line20_pixels got=%0d bad want=0", errs); end
        tick();
        total++; if (bus.wr_ack !== 1'b1 || h_count !== 10'd639) begin bad++; $display("FAIL write_ack got=%0h at h%0d want=1 at h639", bus.wr_ack, h_count); end
        bus.wr_req = 1'b0;
        tick();
        total++; if (bus.wr_ack !== 1'b0) begin bad++; $display("FAIL ack_one_cycle got=%0h want=0", bus.wr_ack); end
        total++; if (ram[1234] !== 8'hA5) begin bad++; $display("FAIL ram_1234 got=%0h want=a5", ram[1234]); end
    endtask

    task automatic test_back_to_back();
        int we_cnt, ack_cnt, consec;
        logic prev_we, first_we;
        we_cnt = 0; ack_cnt = 0; consec = 0; prev_we = 1'b0; first_we = 1'b0;
        set_pos(0, 490);
        bus.wr_addr = 19'd5000;
        bus.wr_data = 8'h77;
        bus.wr_req = 1'b1;
        #1;
        first_we = bus.mem_we;
        for (int i = 0; i < 800; i++) begin
            if (bus.mem_we === 1'b1) begin
                we_cnt++;
                if (prev_we) consec++;
            end
            if (bus.wr_ack === 1'b1) ack_cnt++;
            prev_we = bus.mem_we;
            tick();
        end
        bus.wr_req = 1'b0;
        tick();
        total++; if (first_we !== 1'b1) begin bad++; $display("FAIL b2b_first_we got=%0h want=1", first_we); end
        total++; if (we_cnt != 400) begin bad++; $display("FAIL b2b_writes got=%0d want=400", we_cnt); end
        total++; if (ack_cnt != 400) begin bad++; $display("FAIL b2b_acks got=%0d want=400", ack_cnt); end
        total++; if (consec != 0) begin bad++; $display("FAIL b2b_consecutive_we got=%0d want=0", consec); end
        total++; if (ram[5000] !== 8'h77) begin bad++; $display("FAIL ram_5000 got=%0h want=77", ram[5000]); end
    endtask

    task automatic test_reset_mid();
        set_pos(700, 100);
        bus.wr_addr = 19'd777;
        bus.wr_data = 8'h11;
        bus.wr_req = 1'b1;
        #1;
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL mid_first_we got=%0h want=1", bus.mem_we); end
        tick();
        total++; if (bus.wr_ack !== 1'b1) begin bad++; $display("FAIL mid_ack_before_reset got=%0h want=1", bus.wr_ack); end
        rst = 1'b0;
        #1;
        total++; if (bus.wr_ack !== 1'b0) begin bad++; $display("FAIL mid_ack_killed got=%0h want=0", bus.wr_ack); end
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL mid_pix_valid got=%0h want=0", pix_valid); end
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL mid_we_gated got=%0h want=0", bus.mem_we); end
        rst = 1'b1;
        #1;
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL mid_rerequest_we got=%0h want=1", bus.mem_we); end
        tick();
        total++; if (bus.wr_ack !== 1'b1) begin bad++; $display("FAIL mid_rerequest_ack got=%0h want=1", bus.wr_ack); end
        bus.wr_req = 1'b0;
        tick();
        total++; if (ram[777] !== 8'h11) begin bad++; $display("FAIL ram_777 got=%0h want=11", ram[777]); end
    endtask

    task automatic scan_lines(input int start_v, input int lines, input int want_valid, input string name);
        int errs, vcnt;
        logic       exp_v;
        logic [7:0] exp_d;
        errs = 0; vcnt = 0;
        set_pos(790, (start_v == 0) ? 524 : start_v - 1);
        repeat (10) tick();
        for (int i = 0; i < lines * 800; i++) begin
            exp_v = (h_count < 10'd640) && (v_count < 10'd480);
            exp_d = exp_v ? ram[int'(v_count) * 640 + int'(h_count)] : 8'h00;
            if (pix_valid !== exp_v || pix_data !== exp_d) errs++;
            if (pix_valid === 1'b1) vcnt++;
            tick();
        end
        total++; if (errs != 0) begin bad++; $display("FAIL %s_pixels got=%0d bad want=0", name, errs); end
        total++; if (vcnt != want_valid) begin bad++; $display("FAIL %s_valid_count got=%0d want=%0d", name, vcnt, want_valid); end
    endtask

    task automatic test_frame();
        fill(2);
        scan_lines(0, 3, 1920, "frame_top");
        scan_lines(478, 3, 1280, "frame_bottom");
    endtask

    initial begin
        bus.wr_req = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        test_reset();
        test_prefetch();
        test_write_stall();
        test_back_to_back();
        test_reset_mid();
        test_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
